uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 34 +++
 rtl/uart_tx_scheduler.sv | 133 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit scheduler slice.
//   state_e            : scheduler FSM states (IDLE, ISSUE, HOLD)
//   FRAME_BITS_DEFAULT : bits per UART frame (start, 7 data, parity, stop)
//   countWidth()       : width needed for a down-counter that can hold
//                        the value holdCycles
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int FRAME_BITS_DEFAULT = 10;

    // Guard against a degenerate zero-length hold so the counter never
    // collapses to zero bits.
    function automatic int countWidth(input int holdCycles);
        return (holdCycles < 1) ? 1 : $clog2(holdCycles + 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-way combinational round-robin arbiter. The requester named by the
// pointer has priority; if it is not requesting, the other one may win.
// Ports:
//   valid_i [1:0] : request lines, bit i belongs to requester i
//   ptr_i         : requester that currently has priority
//   grant_o [1:0] : one-hot grant, all zero when nobody requests
// ----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic [1:0] grant_o
);

    // Priority requester first, then the other one, else no grant.
    always_comb begin
        grant_o = 2'b00;
        if (ptr_i == 1'b0) begin
            if (valid_i[0]) begin
                grant_o = 2'b01;
            end else if (valid_i[1]) begin
                grant_o = 2'b10;
            end
        end else begin
            if (valid_i[1]) begin
                grant_o = 2'b10;
            end else if (valid_i[0]) begin
                grant_o = 2'b01;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// ----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART sender between two requesters. A character is accepted in
// IDLE, handed to the sender with a one-cycle tx_start pulse in ISSUE, and
// the scheduler then waits HOLD_CYCLES cycles in HOLD while the frame is
// shifted out, before accepting the next character.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   req_valid [1:0] : per-requester valid
//   req_data0/1     : per-requester 7-bit character
//   req_ready [1:0] : per-requester accept (only the winner, only in IDLE)
//   tx_data         : character for the sender
//   tx_start        : one-cycle start pulse for the sender
//   busy            : high whenever the scheduler is not in IDLE
//   grant_id        : requester owning the current or last frame
//   sent_count      : frames issued since reset (wraps)
// ----------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FRAME_BITS   = FRAME_BITS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [6:0]  req_data0,
    input  logic [6:0]  req_data1,
    output logic [1:0]  req_ready,
    output logic [6:0]  tx_data,
    output logic        tx_start,
    output logic        busy,
    output logic        grant_id,
    output logic [15:0] sent_count
);

    localparam int HOLD_CYCLES = FRAME_BITS * CLKS_PER_BIT;
    localparam int CNT_W       = countWidth(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [6:0]        txData_q, txData_d;
    logic              grantId_q, grantId_d;
    logic [15:0]       sentCount_q, sentCount_d;
    logic              txStart_q, txStart_d;
    logic [1:0]        arbGrant;

    rr_arb2 u_arb (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (arbGrant)
    );

    // Ready and busy are masked by reset so nothing is accepted and the
    // block never looks active while reset is held.
    always_comb begin
        req_ready = 2'b00;
        if ((state_q == IDLE) && !rst) begin
            req_ready = arbGrant;
        end
    end

    assign busy       = (state_q != IDLE) && !rst;
    assign tx_data    = txData_q;
    assign tx_start   = txStart_q;
    assign grant_id   = grantId_q;
    assign sent_count = sentCount_q;

    // Next-state logic. In IDLE the arbiter's grant is the ready signal, so
    // a non-zero grant is by construction a completed valid/ready transfer.
    // tx_start is registered and set on the same edge that enters ISSUE, so
    // it is high for exactly the ISSUE cycle.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        txData_d    = txData_q;
        grantId_d   = grantId_q;
        sentCount_d = sentCount_q;
        txStart_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arbGrant != 2'b00) begin
                    txData_d  = arbGrant[1] ? req_data1 : req_data0;
                    grantId_d = arbGrant[1];
                    ptr_d     = ~arbGrant[1];
                    txStart_d = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                sentCount_d = sentCount_q + 16'd1;
                cnt_d       = HOLD_LOAD;
                state_d     = HOLD;
            end
            HOLD: begin
                // Counter runs HOLD_CYCLES-1 down to 0, one HOLD cycle each.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            cnt_q       <= '0;
            txData_q    <= 7'd0;
            grantId_q   <= 1'b0;
            sentCount_q <= 16'd0;
            txStart_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            txData_q    <= txData_d;
            grantId_q   <= grantId_d;
            sentCount_q <= sentCount_d;
            txStart_q   <= txStart_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Self-checking bench for uart_tx_scheduler with CLKS_PER_BIT=4,
// FRAME_BITS=10. A timeline model predicts every output each cycle; a few
// directed scenarios add hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    localparam int CPB  = 4;
    localparam int FB   = 10;
    localparam int HOLD = CPB * FB;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [6:0]  req_data0;
    logic [6:0]  req_data1;
    logic [1:0]  req_ready;
    logic [6:0]  tx_data;
    logic        tx_start;
    logic        busy;
    logic        grant_id;
    logic [15:0] sent_count;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .CLKS_PER_BIT (CPB),
        .FRAME_BITS   (FB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data0  (req_data0),
        .req_data1  (req_data1),
        .req_ready  (req_ready),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .busy       (busy),
        .grant_id   (grant_id),
        .sent_count (sent_count)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Timeline model: the scheduler is free from cycle mIdleAt onwards; a
    // frame accepted in cycle T pulses at T+1, counts from T+2 and frees
    // the scheduler at T+2+HOLD.
    int          mIdleAt  = 0;
    int          mStartAt = -1;
    int          mSentAt  = -1;
    logic        mPtr     = 1'b0;
    logic [6:0]  mData    = 7'd0;
    logic        mGrant   = 1'b0;
    logic [15:0] mSent    = 16'd0;
    logic [1:0]  accepted;

    // Requester behaviour knobs
    logic [1:0]  enMask    = 2'b00;
    int          refillPct = 0;
    logic        useFixed  = 1'b0;
    logic [6:0]  fix0      = 7'd0;
    logic [6:0]  fix1      = 7'd0;

    // Observations of the DUT taken in the last stepped cycle
    logic [1:0]  lastReady;
    logic        lastBusy;
    logic        lastStart;
    logic [6:0]  lastData;
    logic [15:0] lastSent;

    int          startCyc[$];
    logic [6:0]  startData[$];
    logic        startGrant[$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d actual=0x%0h expected=0x%0h",
                     name, cyc, actual, expected);
        end
    endtask

    function automatic int pickWinner(input logic [1:0] v, input logic p);
        if (v[p]) return int'(p);
        if (v[!p]) return int'(!p);
        return -1;
    endfunction

    // Requesters keep valid and data until accepted; idle ones may raise
    // a new character, and idle ones' data may wander freely.
    task automatic applyStimulus();
        for (int i = 0; i < 2; i++) begin
            if (accepted[i] || !req_valid[i]) begin
                logic [6:0] d;
                d = useFixed ? (i == 0 ? fix0 : fix1) : 7'($urandom_range(0, 127));
                if (i == 0) req_data0 = d; else req_data1 = d;
                req_valid[i] = enMask[i] && ($urandom_range(0, 99) < refillPct);
            end
        end
    endtask

    task automatic stepCycle();
        int         w;
        logic       expIdle;
        logic [1:0] expReady;
        @(negedge clk);
        accepted  = 2'b00;
        lastReady = req_ready;
        lastBusy  = busy;
        lastStart = tx_start;
        lastData  = tx_data;
        lastSent  = sent_count;
        if (rst) begin
            checkOutput("rstReady", 32'(req_ready), 32'd0);
            checkOutput("rstBusy", 32'(busy), 32'd0);
            checkOutput("rstStart", 32'(tx_start), 32'd0);
        end else begin
            expIdle = (cyc >= mIdleAt);
            if (cyc == mSentAt) mSent = mSent + 16'd1;
            w = expIdle ? pickWinner(req_valid, mPtr) : -1;
            expReady = (w < 0) ? 2'b00 : ((w == 1) ? 2'b10 : 2'b01);
            checkOutput("ready", 32'(req_ready), 32'(expReady));
            checkOutput("busy", 32'(busy), 32'(!expIdle));
            checkOutput("txStart", 32'(tx_start), 32'(cyc == mStartAt));
            checkOutput("txData", 32'(tx_data), 32'(mData));
            checkOutput("grantId", 32'(grant_id), 32'(mGrant));
            checkOutput("sentCount", 32'(sent_count), 32'(mSent));
            if (tx_start) begin
                startCyc.push_back(cyc);
                startData.push_back(tx_data);
                startGrant.push_back(grant_id);
            end
            if (w >= 0) begin
                accepted[w] = 1'b1;
                mData    = (w == 1) ? req_data1 : req_data0;
                mGrant   = (w == 1);
                mPtr     = (w != 1);
                mStartAt = cyc + 1;
                mSentAt  = cyc + 2;
                mIdleAt  = cyc + 2 + HOLD;
            end
        end
        @(posedge clk);
        if (rst) begin
            mIdleAt  = 0;
            mStartAt = -1;
            mSentAt  = -1;
            mPtr     = 1'b0;
            mData    = 7'd0;
            mGrant   = 1'b0;
            mSent    = 16'd0;
        end
        cyc++;
        #1;
        applyStimulus();
    endtask

    task automatic clearLog();
        startCyc.delete();
        startData.delete();
        startGrant.delete();
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
    endtask

    initial begin
        int tCyc;
        int rCyc;
        int busyCount;

        rst       = 1'b1;
        req_valid = 2'b00;
        req_data0 = 7'd0;
        req_data1 = 7'd0;
        accepted  = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        pulseReset();

        // Reset state, nothing requested
        stepCycle();
        checkOutput("rstStateData", 32'(lastData), 32'h00);
        checkOutput("rstStateSent", 32'(lastSent), 32'h0);
        checkOutput("rstStateBusy", 32'(lastBusy), 32'h0);

        // Single request from requester 0
        clearLog();
        req_valid = 2'b01;
        req_data0 = 7'h41;
        stepCycle();
        tCyc = cyc - 1;
        checkOutput("singleReady", 32'(lastReady), 32'h1);
        busyCount = 0;
        for (int i = 0; i < 50; i++) begin
            stepCycle();
            if (lastBusy) busyCount++;
        end
        checkOutput("singleBusyLen", 32'(busyCount), 32'd41);
        checkOutput("singleStarts", 32'(startCyc.size()), 32'd1);
        if (startCyc.size() >= 1) begin
            checkOutput("singleStartCyc", 32'(startCyc[0]), 32'(tCyc + 1));
            checkOutput("singleData", 32'(startData[0]), 32'h41);
            checkOutput("singleGrant", 32'(startGrant[0]), 32'h0);
        end
        checkOutput("singleSent", 32'(lastSent), 32'h1);

        // Contention: both requesters always valid
        pulseReset();
        clearLog();
        enMask = 2'b11; refillPct = 100; useFixed = 1'b1;
        fix0 = 7'h11; fix1 = 7'h22;
        req_valid = 2'b11; req_data0 = 7'h11; req_data1 = 7'h22;
        for (int i = 0; i < 3 * (HOLD + 2) + 2; i++) stepCycle();
        checkOutput("contFrames", 32'(startCyc.size() >= 3), 32'd1);
        if (startCyc.size() >= 3) begin
            checkOutput("contData0", 32'(startData[0]), 32'h11);
            checkOutput("contData1", 32'(startData[1]), 32'h22);
            checkOutput("contData2", 32'(startData[2]), 32'h11);
            checkOutput("contGap01", 32'(startCyc[1] - startCyc[0]), 32'd42);
            checkOutput("contGap12", 32'(startCyc[2] - startCyc[1]), 32'd42);
        end
        enMask = 2'b00;
        for (int i = 0; i < 2 * (HOLD + 2) + 4; i++) stepCycle();

        // Only requester 1 valid
        clearLog();
        enMask = 2'b10; fix1 = 7'h55;
        req_valid = 2'b10; req_data1 = 7'h55;
        for (int i = 0; i < 3 * (HOLD + 2) + 2; i++) stepCycle();
        checkOutput("prioFrames", 32'(startCyc.size() >= 3), 32'd1);
        if (startCyc.size() >= 3) begin
            for (int k = 0; k < 3; k++) begin
                checkOutput("prioGrant", 32'(startGrant[k]), 32'h1);
                checkOutput("prioData", 32'(startData[k]), 32'h55);
            end
        end
        enMask = 2'b00;
        for (int i = 0; i < 2 * (HOLD + 2) + 4; i++) stepCycle();

        // Reset ten cycles into HOLD aborts the frame
        refillPct = 0;
        req_valid = 2'b01; req_data0 = 7'h33;
        stepCycle();
        tCyc = cyc - 1;
        for (int i = 0; i < 11; i++) stepCycle();
        rCyc = cyc;
        checkOutput("abortInHold", 32'(rCyc - tCyc), 32'd12);
        pulseReset();
        clearLog();
        req_valid = 2'b11; req_data0 = 7'h66; req_data1 = 7'h77;
        stepCycle();
        checkOutput("postRstReady", 32'(lastReady), 32'h1);
        checkOutput("postRstData", 32'(lastData), 32'h00);
        checkOutput("postRstStart", 32'(lastStart), 32'h0);
        checkOutput("postRstSent", 32'(lastSent), 32'h0);
        for (int i = 0; i < 5; i++) stepCycle();
        checkOutput("postRstFrames", 32'(startCyc.size()), 32'd1);
        if (startCyc.size() >= 1) begin
            checkOutput("postRstStartCyc", 32'(startCyc[0]), 32'(rCyc + 2));
            checkOutput("postRstStartData", 32'(startData[0]), 32'h66);
        end
        for (int i = 0; i < 3 * (HOLD + 2); i++) stepCycle();

        // sent_count wrap
        force dut.sentCount_q = 16'hFFFF;
        mSent = 16'hFFFF;
        stepCycle();
        release dut.sentCount_q;
        stepCycle();
        req_valid = 2'b01; req_data0 = 7'h41;
        for (int i = 0; i < HOLD + 5; i++) stepCycle();
        checkOutput("wrapSent", 32'(lastSent), 32'h0);

        // Random traffic
        enMask = 2'b11; refillPct = 40; useFixed = 1'b0;
        for (int i = 0; i < 1500; i++) stepCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
